// File: rtl/nyq_phase_ctrl.sv
// nyq_phase_ctrl: start/stop, back-pressure-aware phase source for the NYQ
// sampler. Sweeps phase 2^PHASE_W-1 down to 0 on a valid/ready handshake,
// repeats for a latched number of bursts (0 = continuous), then pulses Done.
// Optional macro NYQ_PHASE_MASK_EN adds a per-phase enable mask latched on
// start; disabled phases are skipped at zero cycle cost.
module nyq_phase_ctrl #(
  parameter int BURST_W = 8,
  parameter int PHASE_W = 3
) (
  input  logic               Clk_CI,
  input  logic               Rst_RI,
  input  logic               Start_SI,
  input  logic               Abort_SI,
  input  logic [BURST_W-1:0] Burst_Len_DI,
`ifdef NYQ_PHASE_MASK_EN
  input  logic [2**PHASE_W-1:0] Phase_Mask_DI,
`endif
  output logic [PHASE_W-1:0] Phase_DO,
  output logic               Phase_Valid_SO,
  input  logic               Phase_Ready_SI,
  output logic               Sweep_Done_SO,
  output logic               Busy_SO,
  output logic               Done_SO
);

  localparam int NPH = 2**PHASE_W;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e state_q, state_d;

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               valid_q, valid_d;
  logic               sweep_q, sweep_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic [BURST_W-1:0] len_q, len_d;
  logic [BURST_W-1:0] cnt_inc;

  logic [NPH-1:0] mask_in;
  logic [NPH-1:0] mask_q;
`ifdef NYQ_PHASE_MASK_EN
  logic [NPH-1:0] mask_d;
  assign mask_in = Phase_Mask_DI;
`else
  // Without the mask every phase is enabled; the skip logic folds away.
  assign mask_in = '1;
  assign mask_q  = '1;
`endif

  // Highest set index of an enable vector (all-ones if none set).
  function automatic logic [PHASE_W-1:0] top_en(input logic [NPH-1:0] m);
    top_en = '1;
    for (int i = 0; i < NPH; i++)
      if (m[i]) top_en = PHASE_W'(i);
  endfunction

  // Enabled phases strictly below the current one; drives next-phase and
  // end-of-sweep detection.
  logic [NPH-1:0] below_m;
  genvar gi;
  generate
    for (gi = 0; gi < NPH; gi++) begin : g_below
      assign below_m[gi] = mask_q[gi] && (PHASE_W'(gi) < phase_q);
    end
  endgenerate

  logic               accept;
  logic               sweep_last;
  logic               final_sweep;
  logic               start_ok;
  logic [PHASE_W-1:0] next_ph;

  assign accept      = valid_q & Phase_Ready_SI;
  assign sweep_last  = ~|below_m;
  assign next_ph     = top_en(below_m);
  assign cnt_inc     = cnt_q + BURST_W'(1);
  assign final_sweep = (len_q != '0) && (cnt_inc == len_q);
  assign start_ok    = Start_SI & (|mask_in);

  // State register
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode; abort wins over a simultaneous accept
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN: begin
        if (Abort_SI)                                  state_d = IDLE;
        else if (accept && sweep_last && final_sweep)  state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and sweep bookkeeping
  always_comb begin
    phase_d = phase_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
`ifdef NYQ_PHASE_MASK_EN
    mask_d  = mask_q;
`endif
    sweep_d = 1'b0;
    busy_d  = (state_d == RUN) || (state_d == DONE);
    done_d  = (state_d == DONE);
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          len_d   = Burst_Len_DI;
          cnt_d   = '0;
`ifdef NYQ_PHASE_MASK_EN
          mask_d  = mask_in;
`endif
          phase_d = top_en(mask_in);
          valid_d = 1'b1;
        end
      end
      RUN: begin
        if (Abort_SI) begin
          phase_d = '1;
          valid_d = 1'b0;
        end else if (accept) begin
          if (sweep_last) begin
            cnt_d   = cnt_inc;
            sweep_d = 1'b1;
            if (final_sweep) begin
              phase_d = '1;
              valid_d = 1'b0;
            end else begin
              // Back-to-back sweeps: restart with no bubble
              phase_d = top_en(mask_q);
            end
          end else begin
            phase_d = next_ph;
          end
        end
      end
      DONE: begin
        phase_d = '1;
        valid_d = 1'b0;
      end
      default: begin
        phase_d = '1;
        valid_d = 1'b0;
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      phase_q <= '1;
      valid_q <= 1'b0;
      sweep_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      phase_q <= phase_d;
      valid_q <= valid_d;
      sweep_q <= sweep_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

`ifdef NYQ_PHASE_MASK_EN
  // Latched enable mask; reset to all-enabled so below_m is well defined
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) mask_q <= '1;
    else        mask_q <= mask_d;
  end
`endif

  assign Phase_DO       = phase_q;
  assign Phase_Valid_SO = valid_q;
  assign Sweep_Done_SO  = sweep_q;
  assign Busy_SO        = busy_q;
  assign Done_SO        = done_q;

endmodule

// File: tb/tb_nyq_phase_ctrl.sv
// Scoreboard bench for nyq_phase_ctrl: stimulus pushes the expected accepted
// phase stream; a negedge monitor pops and compares on every handshake.
module tb_nyq_phase_ctrl;
  localparam int BW  = 8;
  localparam int PW  = 3;
  localparam int NPH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          ready = 1'b0;
  logic [BW-1:0] blen = '0;
  logic [NPH-1:0] mask = 8'hFF;
  logic [PW-1:0] phase;
  logic          valid, sdone, busy, done;

  int n_chk = 0;
  int n_fail = 0;
  int exp_ph[$];
  int sw_seen = 0;
  int dn_seen = 0;
  int ph_extra = 0;
  bit prev_stall = 0;
  int prev_ph = 0;

  always #5 clk = ~clk;

  nyq_phase_ctrl #(.BURST_W(BW), .PHASE_W(PW)) dut (
    .Clk_CI        (clk),
    .Rst_RI        (rst),
    .Start_SI      (start),
    .Abort_SI      (abort),
    .Burst_Len_DI  (blen),
`ifdef NYQ_PHASE_MASK_EN
    .Phase_Mask_DI (mask),
`endif
    .Phase_DO      (phase),
    .Phase_Valid_SO(valid),
    .Phase_Ready_SI(ready),
    .Sweep_Done_SO (sdone),
    .Busy_SO       (busy),
    .Done_SO       (done)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: enabled phases in presentation order for one sweep
  function automatic int n_en(input logic [NPH-1:0] m);
    int n = 0;
    for (int i = 0; i < NPH; i++) if (m[i]) n++;
    return n;
  endfunction

  function automatic int top_of(input logic [NPH-1:0] m);
    for (int p = NPH-1; p >= 0; p--) if (m[p]) return p;
    return NPH-1;
  endfunction

  function automatic int seq_at(input logic [NPH-1:0] m, input int idx);
    int k = idx % n_en(m);
    for (int p = NPH-1; p >= 0; p--)
      if (m[p]) begin
        if (k == 0) return p;
        k--;
      end
    return -1;
  endfunction

  task automatic clear_sb;
    exp_ph.delete();
    sw_seen = 0; dn_seen = 0; ph_extra = 0;
  endtask

  // Monitor: handshake scoreboard, stall stability, pulse counting
  always @(negedge clk) begin
    if (rst) prev_stall = 0;
    else begin
      if (prev_stall && valid) chk("stall_hold", int'(phase), prev_ph);
      if (valid && ready) begin
        if (exp_ph.size() == 0) ph_extra++;
        else chk("phase_seq", int'(phase), exp_ph.pop_front());
      end
      if (sdone) sw_seen++;
      if (done)  dn_seen++;
      prev_stall = valid && !ready;
      prev_ph    = int'(phase);
    end
  end

  // mode 0: ready held high, 1: toggle starting low, 2: random
  task automatic run_burst(input int len, input logic [NPH-1:0] m, input int mode);
    int  e = n_en(m);
    int  vcnt = 0;
    int  cyc = 0;
    bit  got = 0;
    clear_sb();
    for (int i = 0; i < len*e; i++) exp_ph.push_back(seq_at(m, i));
    blen = BW'(len); mask = m; start = 1'b1; ready = 1'b0;
    tick();
    start = 1'b0;
    chk("first_valid", int'(valid), 1);
    chk("first_phase", int'(phase), top_of(m));
    chk("busy_run", int'(busy), 1);
    while (cyc < 2000) begin
      if (valid) vcnt++;
      ready = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      tick();
      cyc++;
      if (done) begin got = 1; break; end
    end
    chk("done_seen", int'(got), 1);
    chk("done_sweep", int'(sdone), 1);
    chk("done_busy", int'(busy), 1);
    chk("done_valid", int'(valid), 0);
    chk("done_phase", int'(phase), NPH-1);
    if (mode == 0) begin
      chk("gapless_valid", vcnt, len*e);
      chk("gapless_cycles", cyc, len*e);
    end
    if (mode == 1) chk("toggle_valid", vcnt, 2*len*e);
    // Start during DONE must be ignored
    start = 1'b1; ready = 1'($urandom_range(0, 1));
    tick();
    start = 1'b0; ready = 1'b0;
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);
    chk("idle_valid", int'(valid), 0);
    chk("phase_left", exp_ph.size(), 0);
    chk("sweep_count", sw_seen, len);
    chk("done_count", dn_seen, 1);
    chk("phase_extra", ph_extra, 0);
  endtask

  // Continuous burst: k accepts, then abort together with ready
  task automatic run_abort(input int k, input logic [NPH-1:0] m);
    int e = n_en(m);
    clear_sb();
    for (int i = 0; i <= k; i++) exp_ph.push_back(seq_at(m, i));
    blen = '0; mask = m; start = 1'b1; ready = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < k; i++) begin
      ready = 1'b1;
      tick();
    end
    abort = 1'b1; ready = 1'b1;
    tick();
    abort = 1'b0; ready = 1'b0;
    chk("abort_valid", int'(valid), 0);
    chk("abort_phase", int'(phase), NPH-1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_sweep", int'(sdone), 0);
    chk("abort_done", int'(done), 0);
    tick();
    chk("abort_idle", int'(busy), 0);
    chk("abort_sweeps", sw_seen, k / e);
    chk("abort_dones", dn_seen, 0);
    chk("abort_left", exp_ph.size(), 0);
    chk("abort_extra", ph_extra, 0);
  endtask

  task automatic run_reset_mid;
    clear_sb();
    for (int i = 0; i < 16; i++) exp_ph.push_back(seq_at(8'hFF, i));
    blen = 8'd2; mask = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin ready = 1'b1; tick(); end
    chk("pre_rst_phase", int'(phase), 4);
    start = 1'b1; ready = 1'b0;
    tick();
    start = 1'b0;
    chk("run_start_ignored", int'(phase), 4);
    chk("run_start_valid", int'(valid), 1);
    rst = 1'b1;
    tick();
    chk("rst_phase", int'(phase), NPH-1);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sweep", int'(sdone), 0);
    rst = 1'b0;
    exp_ph.delete();
    tick();
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_valid", int'(valid), 0);
    chk("post_rst_dones", dn_seen, 0);
  endtask

  initial begin
    logic [NPH-1:0] m;
    repeat (3) tick();
    chk("reset_phase", int'(phase), NPH-1);
    chk("reset_valid", int'(valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_sweep", int'(sdone), 0);
    rst = 1'b0;
    tick();

    run_burst(1, 8'hFF, 0);
    run_burst(3, 8'hFF, 0);
    run_burst(1, 8'hFF, 1);
    run_abort(20, 8'hFF);
    run_reset_mid();

`ifdef NYQ_PHASE_MASK_EN
    run_burst(2, 8'hA5, 0);
    mask = 8'h00; blen = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("mask0_busy", int'(busy), 0);
    chk("mask0_valid", int'(valid), 0);
    tick();
    chk("mask0_idle", int'(busy), 0);
`endif

    for (int r = 0; r < 6; r++) begin
      m = 8'hFF;
`ifdef NYQ_PHASE_MASK_EN
      do m = NPH'($urandom); while (m == '0);
`endif
      run_burst($urandom_range(1, 3), m, $urandom_range(0, 2));
    end
    for (int r = 0; r < 3; r++) begin
      m = 8'hFF;
`ifdef NYQ_PHASE_MASK_EN
      do m = NPH'($urandom); while (m == '0);
`endif
      run_abort($urandom_range(1, 30), m);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard bound on run time
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1, "timeout");
  end

endmodule
